// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and mux selects, counts retired instructions, traps on bad opcode or memory timeout.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               r_illegal;
    logic               r_bus_err;
    logic [WAIT_W-1:0]  r_wait_cnt;

    logic w_retire;
    logic w_set_illegal;
    logic w_set_bus_err;
    logic w_timeout;
    logic w_is_r;
    logic w_is_load;
    logic w_is_store;

    assign w_is_r     = (opcode == OP_R);
    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    // Fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LIMIT);

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                if (w_is_r || (opcode == OP_I) || w_is_load || w_is_store) begin
                    w_next = S_EXEC;
                end else if (opcode == OP_BR) begin
                    w_next = S_BRANCH;
                end else begin
                    w_next        = S_TRAP;
                    w_set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = w_is_r ? 2'b00 : 2'b10;
                alu_op    = w_is_r ? 2'b10 : 2'b00;
                w_next    = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = w_is_load;
                mem_write = !w_is_load;
                if (mem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next        = S_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = w_is_load;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = zero;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase

        // Reset gates the strobes combinationally so an in-flight request drops immediately.
        if (!rst_n) begin
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_retired  <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)      r_retired <= r_retired + CNT_W'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
            if ((w_next != r_state) || mem_ready || !((r_state == S_FETCH) || (r_state == S_MEM)))
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    assign retired = r_retired;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state   = r_state;

endmodule
